device_scheduler_rr: RTL
========================

Name: device_scheduler_rr

Overview:
- Shares one memory-mapped device (SDRAM, EEPROM, cart control) between NUM_CONTROLLERS bus masters (N64 PI, USB PC).
- Buffers one pending request per controller and grants the device round-robin.
- Issues exactly one device transaction at a time and routes the read acknowledge and data back to the owning controller.
- Sits between master request buses and a single memory_* device instance.

Parameters:
- NUM_CONTROLLERS, 2, number of requesting masters; index 0 has highest priority after reset.
- ADDRESS_WIDTH, 25, device word address width.
- DEVICE_BANK, 4'd1, bank value this device decodes.
- TIMEOUT_CYCLES, 1024, read-ack watchdog limit (used only with the optional feature).

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_request  in  N  per-controller request strobe, 1 cycle
- i_write  in  N  per-controller write flag
- i_bank  in  4*N  per-controller bank
- i_address  in  ADDRESS_WIDTH*N  per-controller address
- i_data  in  32*N  per-controller write data
- o_busy  out  N  controller slot occupied
- o_ack  out  N  read-completion strobe
- o_data  out  32*N  read data per controller
- o_device_request  out  1  device strobe, 1 cycle
- o_device_write  out  1  device write flag
- i_device_busy  in  1  device cannot accept
- i_device_ack  in  1  device read-completion strobe
- i_device_data  in  32  device read data
- o_device_address  out  ADDRESS_WIDTH  device address
- o_device_data  out  32  device write data
- o_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async, i_reset_n=0): all slots empty; o_busy=0; o_ack=0; o_data=0; o_device_request=0; o_device_write=0; o_device_address=0; o_device_data=0; o_timeout=0; round-robin pointer=0; state IDLE.
- Accept: i_request[i] && i_bank[i]==DEVICE_BANK && slot i empty → latch write/address/data into slot i; o_busy[i]=1 from the next cycle.
- Requests with a non-matching bank are ignored.
- Requests while slot i is full are dropped; controllers must not issue while o_busy[i]=1.
- Arbitration: in IDLE with any slot full and !i_device_busy, grant the first full slot at or after the pointer, wrapping at N-1 to 0.
  - Pointer becomes grant+1 (mod N).
  - A slot accepted in the same cycle is not eligible until the next cycle.
- State machine:
  - IDLE → ISSUE: on a grant.
  - ISSUE: o_device_request=1 for exactly one cycle, with o_device_write, o_device_address and o_device_data from the granted slot.
    - Write: slot cleared and o_busy[g] falls in the next cycle; → IDLE. No o_ack for writes.
    - Read: → WAIT_ACK.
  - WAIT_ACK: on i_device_ack, o_ack[g]=1 for one cycle and o_data[g]=i_device_data (held until the next ack to g); slot cleared, o_busy[g]=0 in the same cycle; → IDLE.
- Latency: request at cycle 0 with idle device → device strobe at cycle 2. Read ack is forwarded with one registered cycle.
- i_device_ack outside WAIT_ACK is ignored.
- Back-to-back: a new grant is possible in the cycle after returning to IDLE.
- Reset mid-transaction: everything is abandoned; no ack is emitted.

Optional Feature:
- Macro DEVICE_SCHEDULER_TIMEOUT_EN.
- Defined: cycle counter runs in WAIT_ACK. On reaching TIMEOUT_CYCLES without i_device_ack:
  - o_ack[g]=1 with o_data[g]=32'hFFFF_FFFF;
  - o_timeout set (sticky until reset);
  - → IDLE.
  - A late i_device_ack is ignored.
- Undefined: no counter; WAIT_ACK waits indefinitely; o_timeout tied 0.

Test Plan:
- Reset: hold i_reset_n=0 mid-read → all outputs 0; after release no o_ack appears.
- Single read: ctrl0 read, bank=DEVICE_BANK, addr 0x12345 → o_device_request at +2 cycles with address 0x12345 and write=0. Device acks with 0xDEADBEEF → o_ack[0] one cycle, o_data[0]=0xDEADBEEF, o_busy[0] falls.
- Fairness: ctrl0 and ctrl1 both request every time the slot frees, device always ready → grants alternate 0,1,0,1 across 8 transactions.
- Bank filter/write: ctrl1 write with bank≠DEVICE_BANK → no device activity, o_busy stays 0. Same with matching bank and data 0xA5A5A5A5 → one device write strobe, no o_ack.
- Device busy: i_device_busy=1 for 10 cycles with ctrl0 pending → no o_device_request. Strobe occurs 1 cycle after busy drops.
- Timeout (macro on, TIMEOUT_CYCLES=16): read never acked → o_ack[0] with 0xFFFFFFFF after 16 cycles in WAIT_ACK, o_timeout=1. A later i_device_ack is ignored.

Source files
------------

// File: rtl/device_scheduler_rr.sv
// device_scheduler_rr: shares one memory device among NUM_CONTROLLERS masters with round-robin grants.
// Optional read-ack watchdog enabled by macro DEVICE_SCHEDULER_TIMEOUT_EN.
module device_scheduler_rr #(
    parameter int         NUM_CONTROLLERS = 2,
    parameter int         ADDRESS_WIDTH   = 25,
    parameter logic [3:0] DEVICE_BANK     = 4'd1,
    parameter int         TIMEOUT_CYCLES  = 1024
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset_n,
    input  logic [NUM_CONTROLLERS-1:0]             i_request,
    input  logic [NUM_CONTROLLERS-1:0]             i_write,
    input  logic [4*NUM_CONTROLLERS-1:0]           i_bank,
    input  logic [ADDRESS_WIDTH*NUM_CONTROLLERS-1:0] i_address,
    input  logic [32*NUM_CONTROLLERS-1:0]          i_data,
    output logic [NUM_CONTROLLERS-1:0]             o_busy,
    output logic [NUM_CONTROLLERS-1:0]             o_ack,
    output logic [32*NUM_CONTROLLERS-1:0]          o_data,
    output logic                                   o_device_request,
    output logic                                   o_device_write,
    input  logic                                   i_device_busy,
    input  logic                                   i_device_ack,
    input  logic [31:0]                            i_device_data,
    output logic [ADDRESS_WIDTH-1:0]               o_device_address,
    output logic [31:0]                            o_device_data,
    output logic                                   o_timeout
);
    localparam int N  = NUM_CONTROLLERS;
    localparam int IW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

    state_t                   state, state_next;
    logic [N-1:0]             valid, wr;
    logic [ADDRESS_WIDTH-1:0] addr [N];
    logic [31:0]              wdata [N];
    logic [31:0]              rdata [N];
    logic [IW-1:0]            ptr, pick, owner;
    logic                     found, grant, done, expire;
    int                       idx;

    // First occupied slot at or after the pointer; slots filled this cycle are not yet visible.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && valid[IW'(idx)]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    assign grant  = state == IDLE && found && !i_device_busy;
    assign done   = state == WAIT_ACK && (i_device_ack || expire);
    assign o_busy = valid;

    always_comb begin
        state_next = grant ? ISSUE :
                     state == ISSUE ? (wr[owner] ? IDLE : WAIT_ACK) :
                     done ? IDLE : state;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state            <= IDLE;
            ptr              <= '0;
            owner            <= '0;
            valid            <= '0;
            wr               <= '0;
            o_ack            <= '0;
            o_device_request <= 1'b0;
            o_device_write   <= 1'b0;
            o_device_address <= '0;
            o_device_data    <= '0;
            for (int i = 0; i < N; i++) begin
                addr[i]  <= '0;
                wdata[i] <= '0;
                rdata[i] <= '0;
            end
        end else begin
            state            <= state_next;
            o_ack            <= '0;
            o_device_request <= grant;
            if (grant) begin
                owner            <= pick;
                ptr              <= (pick == IW'(N - 1)) ? '0 : pick + 1'b1;
                o_device_write   <= wr[pick];
                o_device_address <= addr[pick];
                o_device_data    <= wdata[pick];
            end
            for (int i = 0; i < N; i++) begin
                if (i_request[i] && i_bank[4*i +: 4] == DEVICE_BANK && !valid[i]) begin
                    valid[i] <= 1'b1;
                    wr[i]    <= i_write[i];
                    addr[i]  <= i_address[ADDRESS_WIDTH*i +: ADDRESS_WIDTH];
                    wdata[i] <= i_data[32*i +: 32];
                end
            end
            if (state == ISSUE && wr[owner])
                valid[owner] <= 1'b0;
            if (done) begin
                valid[owner] <= 1'b0;
                o_ack[owner] <= 1'b1;
                rdata[owner] <= expire ? '1 : i_device_data;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_data
        assign o_data[32*g +: 32] = rdata[g];
    end

`ifdef DEVICE_SCHEDULER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] count;

    assign expire = state == WAIT_ACK && !i_device_ack && count == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count     <= '0;
            o_timeout <= 1'b0;
        end else begin
            count <= (state == WAIT_ACK) ? count + 1'b1 : '0;
            if (expire)
                o_timeout <= 1'b1;
        end
    end
`else
    assign expire    = 1'b0;
    assign o_timeout = 1'b0;
`endif
endmodule
